// File: rtl/if_fetch_icache.sv
// Instruction-fetch stage: PC register plus a direct-mapped, one-word-per-line
// instruction cache. Hits are served in one cycle; each miss issues one word fetch.
module if_fetch_icache #(
  parameter int          INDEX_BITS = 6,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  input  logic        id_ready_i,
  output logic        if_valid_o,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_done_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_pc_i
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic {RUN, MISS} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic                    vld_d, req_d;
  logic [31:0]             inst_d, ifpc_d, addr_d;

  logic [LINES-1:0]        line_vld_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [31:0]             data_q [LINES];

  logic [INDEX_BITS-1:0]   idx, fill_idx;
  logic [TAG_W-1:0]        tag, fill_tag;
  logic                    hit, slot_free, match_done, fill_en;

  assign idx        = pc_q[INDEX_BITS+1:2];
  assign tag        = pc_q[31:INDEX_BITS+2];
  assign fill_idx   = inst_pc_i[INDEX_BITS+1:2];
  assign fill_tag   = inst_pc_i[31:INDEX_BITS+2];
  assign hit        = line_vld_q[idx] && (tag_q[idx] == tag);
  assign slot_free  = !if_valid_o || id_ready_i;
  assign match_done = inst_done_i && (inst_pc_i == inst_addr_o);
  // Any aligned completion fills, even a stale one left over from a redirect.
  assign fill_en    = inst_done_i && (inst_pc_i[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = if_valid_o;
    inst_d  = if_inst_o;
    ifpc_d  = if_pc_o;
    req_d   = inst_req_o;
    addr_d  = inst_addr_o;
    if (jump_i) begin
      pc_d    = jump_addr_i & ~32'h3;
      vld_d   = 1'b0;
      req_d   = 1'b0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (hit) begin
            if (slot_free) begin
              inst_d = data_q[idx];
              ifpc_d = pc_q;
              vld_d  = 1'b1;
              pc_d   = pc_q + 32'd4;
            end
          end else begin
            state_d = MISS;
            req_d   = 1'b1;
            addr_d  = pc_q;
            if (slot_free) vld_d = 1'b0;
          end
        end
        MISS: begin
          if (match_done) begin
            req_d   = 1'b0;
            state_d = RUN;
          end
          if (id_ready_i && if_valid_o) vld_d = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      if_valid_o  <= 1'b0;
      if_inst_o   <= '0;
      if_pc_o     <= '0;
      inst_req_o  <= 1'b0;
      inst_addr_o <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_valid_o  <= vld_d;
      if_inst_o   <= inst_d;
      if_pc_o     <= ifpc_d;
      inst_req_o  <= req_d;
      inst_addr_o <= addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         line_vld_q           <= '0;
    else if (fill_en) line_vld_q[fill_idx] <= 1'b1;
  end

  // Tag and data storage carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= inst_i;
    end
  end

endmodule

// File: tb/tb_if_fetch_icache.sv
// Bench for if_fetch_icache: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a line-addressed cache reference model.
module tb_if_fetch_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        id_ready_i = 1'b0;
  logic        if_valid_o;
  logic [31:0] if_inst_o, if_pc_o;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_done_i = 1'b0;
  logic [31:0] inst_i = '0;
  logic [31:0] inst_pc_i = '0;

  always #5 clk = ~clk;

  if_fetch_icache #(.INDEX_BITS(6), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .id_ready_i(id_ready_i), .if_valid_o(if_valid_o), .if_inst_o(if_inst_o),
    .if_pc_o(if_pc_o), .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_done_i(inst_done_i), .inst_i(inst_i), .inst_pc_i(inst_pc_i)
  );

  int n_chk = 0;
  int n_err = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'h13;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cache held as line index -> full word address and data.
  logic [31:0] m_pc, m_inst, m_ifpc, m_addr;
  bit          m_v, m_req, m_miss;
  logic [31:0] c_addr [int];
  logic [31:0] c_data [int];

  task automatic m_reset();
    m_pc = 32'h0; m_inst = '0; m_ifpc = '0; m_addr = '0;
    m_v = 0; m_req = 0; m_miss = 0;
    c_addr.delete(); c_data.delete();
  endtask

  task automatic m_step();
    int idx;
    bit free, hit;
    free = !m_v || id_ready_i;
    if (jump_i) begin
      m_pc = jump_addr_i & ~32'h3; m_v = 0; m_miss = 0; m_req = 0;
    end else if (!m_miss) begin
      idx = int'((m_pc >> 2) % 64);
      hit = c_addr.exists(idx) && (c_addr[idx] == m_pc);
      if (hit) begin
        if (free) begin
          m_inst = c_data[idx]; m_ifpc = m_pc; m_v = 1; m_pc = m_pc + 32'd4;
        end
      end else begin
        m_miss = 1; m_req = 1; m_addr = m_pc;
        if (free) m_v = 0;
      end
    end else begin
      if (inst_done_i && inst_pc_i == m_addr) begin m_req = 0; m_miss = 0; end
      if (id_ready_i && m_v) m_v = 0;
    end
    if (inst_done_i && inst_pc_i[1:0] == 2'b00) begin
      idx = int'((inst_pc_i >> 2) % 64);
      c_addr[idx] = inst_pc_i;
      c_data[idx] = inst_i;
    end
  endtask

  task automatic cyc(input bit j, input logic [31:0] ja, input bit r, input bit d,
                     input logic [31:0] pa);
    jump_i = j; jump_addr_i = ja; id_ready_i = r;
    inst_done_i = d; inst_pc_i = pa; inst_i = mem(pa);
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic compare_model();
    chk("rnd_valid", 32'(if_valid_o), 32'(m_v));
    chk("rnd_pc",    if_pc_o, m_ifpc);
    chk("rnd_inst",  if_inst_o, m_inst);
    chk("rnd_req",   32'(inst_req_o), 32'(m_req));
    chk("rnd_addr",  inst_addr_o, m_addr);
  endtask

  typedef struct {
    bit          rdy;
    bit          done;
    logic [31:0] ipc;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] einst;
    bit          ereq;
    logic [31:0] eaddr;
  } vec_t;

  function automatic vec_t mkv(input bit rdy, input bit done, input logic [31:0] ipc,
                               input bit ev, input logic [31:0] epc, input logic [31:0] einst,
                               input bit ereq, input logic [31:0] eaddr);
    vec_t v;
    v.rdy = rdy; v.done = done; v.ipc = ipc; v.ev = ev;
    v.epc = epc; v.einst = einst; v.ereq = ereq; v.eaddr = eaddr;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    int wait_cnt;
    bit j, r, d;
    logic [31:0] ja, pa;

    // Cold start with stale fills of 4, 8, C and a conflicting 0x100 while 0 is pending.
    tbl[0]  = mkv(1, 0, 32'h0,   0, 32'h0, 32'h0,       1, 32'h0);
    tbl[1]  = mkv(1, 1, 32'h4,   0, 32'h0, 32'h0,       1, 32'h0);
    tbl[2]  = mkv(1, 1, 32'h8,   0, 32'h0, 32'h0,       1, 32'h0);
    tbl[3]  = mkv(1, 1, 32'hC,   0, 32'h0, 32'h0,       1, 32'h0);
    tbl[4]  = mkv(1, 1, 32'h100, 0, 32'h0, 32'h0,       1, 32'h0);
    tbl[5]  = mkv(1, 1, 32'h0,   0, 32'h0, 32'h0,       0, 32'h0);
    tbl[6]  = mkv(1, 0, 32'h0,   1, 32'h0, 32'h13,      0, 32'h0);
    tbl[7]  = mkv(1, 0, 32'h0,   1, 32'h4, mem(32'h4),  0, 32'h0);
    tbl[8]  = mkv(0, 0, 32'h0,   1, 32'h4, mem(32'h4),  0, 32'h0);
    tbl[9]  = mkv(0, 0, 32'h0,   1, 32'h4, mem(32'h4),  0, 32'h0);
    tbl[10] = mkv(0, 0, 32'h0,   1, 32'h4, mem(32'h4),  0, 32'h0);
    tbl[11] = mkv(1, 0, 32'h0,   1, 32'h8, mem(32'h8),  0, 32'h0);
    tbl[12] = mkv(1, 0, 32'h0,   1, 32'hC, mem(32'hC),  0, 32'h0);
    tbl[13] = mkv(1, 0, 32'h0,   0, 32'hC, mem(32'hC),  1, 32'h10);

    @(negedge clk);
    chk("reset_valid", 32'(if_valid_o), 32'h0);
    chk("reset_req",   32'(inst_req_o), 32'h0);
    chk("reset_inst",  if_inst_o, 32'h0);
    chk("reset_pc",    if_pc_o, 32'h0);
    chk("reset_addr",  inst_addr_o, 32'h0);
    rst = 1'b1;
    m_reset();

    for (int i = 0; i < 14; i++) begin
      cyc(0, 32'h0, tbl[i].rdy, tbl[i].done, tbl[i].ipc);
      chk($sformatf("tbl%0d_valid", i), 32'(if_valid_o), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_pc", i),    if_pc_o, tbl[i].epc);
      chk($sformatf("tbl%0d_inst", i),  if_inst_o, tbl[i].einst);
      chk($sformatf("tbl%0d_req", i),   32'(inst_req_o), 32'(tbl[i].ereq));
      chk($sformatf("tbl%0d_addr", i),  inst_addr_o, tbl[i].eaddr);
    end

    // Redirect in the middle of a miss, then a stale completion for the old address.
    cyc(1, 32'h40, 1, 0, 32'h0);
    chk("jump_clr_valid", 32'(if_valid_o), 32'h0);
    chk("jump_clr_req",   32'(inst_req_o), 32'h0);
    cyc(0, 32'h0, 1, 0, 32'h0);
    chk("miss40_req",  32'(inst_req_o), 32'h1);
    chk("miss40_addr", inst_addr_o, 32'h40);
    cyc(0, 32'h0, 1, 0, 32'h0);
    cyc(1, 32'h100, 1, 0, 32'h0);
    chk("redir_valid", 32'(if_valid_o), 32'h0);
    chk("redir_req",   32'(inst_req_o), 32'h0);
    cyc(0, 32'h0, 1, 0, 32'h0);
    chk("reissue_req",  32'(inst_req_o), 32'h1);
    chk("reissue_addr", inst_addr_o, 32'h100);
    cyc(0, 32'h0, 1, 1, 32'h40);
    chk("stale_req",  32'(inst_req_o), 32'h1);
    chk("stale_addr", inst_addr_o, 32'h100);
    cyc(0, 32'h0, 1, 1, 32'h100);
    chk("done100_req", 32'(inst_req_o), 32'h0);
    cyc(0, 32'h0, 1, 0, 32'h0);
    chk("hit100_valid", 32'(if_valid_o), 32'h1);
    chk("hit100_pc",    if_pc_o, 32'h100);
    chk("hit100_inst",  if_inst_o, mem(32'h100));
    cyc(1, 32'h40, 1, 0, 32'h0);
    cyc(0, 32'h0, 1, 0, 32'h0);
    chk("stalefill40_valid", 32'(if_valid_o), 32'h1);
    chk("stalefill40_pc",    if_pc_o, 32'h40);
    chk("stalefill40_inst",  if_inst_o, mem(32'h40));

    // Line 0 now holds 0x100, so fetching 0 conflicts and misses.
    cyc(1, 32'h0, 1, 0, 32'h0);
    cyc(0, 32'h0, 1, 0, 32'h0);
    chk("conflict_req",  32'(inst_req_o), 32'h1);
    chk("conflict_addr", inst_addr_o, 32'h0);

    // Asynchronous reset between clock edges while a request is outstanding.
    #2 rst = 1'b0;
    #1;
    chk("areset_req",   32'(inst_req_o), 32'h0);
    chk("areset_valid", 32'(if_valid_o), 32'h0);
    chk("areset_addr",  inst_addr_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    cyc(0, 32'h0, 1, 0, 32'h0);
    chk("post_reset_req",   32'(inst_req_o), 32'h1);
    chk("post_reset_addr",  inst_addr_o, 32'h0);
    chk("post_reset_valid", 32'(if_valid_o), 32'h0);

    // Randomized traffic: redirects (some misaligned, some near the top of memory),
    // decode back-pressure, variable memory latency and spurious completions.
    wait_cnt = 2;
    for (int n = 0; n < 3000; n++) begin
      j  = ($urandom % 16) == 0;
      ja = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : $urandom_range(0, 511);
      r  = ($urandom % 4) != 0;
      d  = 0;
      pa = 32'h0;
      if (m_req) begin
        if (wait_cnt == 0) begin
          d = 1; pa = m_addr; wait_cnt = int'($urandom % 6);
        end else begin
          wait_cnt--;
        end
      end else if (($urandom % 12) == 0) begin
        d = 1; pa = $urandom_range(0, 511);
      end
      cyc(j, ja, r, d, pa);
      compare_model();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
